// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles big-endian words from a byte stream,
// writes them to the fetch memory, and gates the pipeline on a verified XOR checksum.
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_run,
    output logic [15:0] words_loaded
);
    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      len;
    logic [15:0]      len_n;
    logic [7:0]       csum;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             start_ok;
    logic             last_word;
    logic             nxt_busy;

    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_n     = {len[15:8], rx_data};
    assign last_word = (16'(idx) + 16'd1) == len;
    assign nxt_busy  = (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                       (state_nxt == S_DATA)   || (state_nxt == S_CSUM);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (32'(len_n) > DEPTH)  state_nxt = S_ERROR;
                    else if (len_n == 16'd0) state_nxt = S_CSUM;
                    else                     state_nxt = S_DATA;
                end
            end
            S_DATA: if (accept && byte_cnt == 2'd3 && last_word) state_nxt = S_CSUM;
            S_CSUM: if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_run      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            words_loaded <= '0;
            len          <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            idx          <= '0;
        end else begin
            state    <= state_nxt;
            rx_ready <= nxt_busy;
            busy     <= nxt_busy;
            done     <= (state_nxt == S_DONE);
            error    <= (state_nxt == S_ERROR);
            cpu_run  <= (state_nxt == S_DONE);
            mem_we   <= 1'b0;

            if (start_ok) begin
                csum         <= '0;
                byte_cnt     <= '0;
                idx          <= '0;
                words_loaded <= '0;
            end

            if (accept) begin
                csum <= csum ^ rx_data;
                unique case (state)
                    S_LEN_HI: len[15:8] <= rx_data;
                    S_LEN_LO: len[7:0]  <= rx_data;
                    S_DATA: begin
                        shift    <= {shift[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_wdata    <= {shift, rx_data};
                            mem_addr     <= BASE_ADDR + (32'(idx) << 2);
                            idx          <= idx + IDX_W'(1);
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
